// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The master issues requests; the sequencer (slave) returns status, result and flags.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carryout, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carryout, overflow, zero
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: drives one 1-bit ALU slice LSB-first for WIDTH cycles, then
// publishes the assembled result with carry/overflow/zero flags.
module alu1bit (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] op_i,
    output logic       out_o,
    output logic       cout_o
);
    logic b_eff;
    logic sum;

    always_comb begin
        // SUB and SLT add the inverted operand; the +1 comes from the seeded carry
        b_eff  = (op_i == 3'b001 || op_i == 3'b011) ? ~b_i : b_i;
        sum    = a_i ^ b_eff ^ cin_i;
        cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
        case (op_i)
            3'b010:  out_o = a_i ^ b_i;
            3'b100:  out_o = a_i & b_i;
            3'b101:  out_o = ~(a_i & b_i);
            3'b110:  out_o = ~(a_i | b_i);
            3'b111:  out_o = a_i | b_i;
            default: out_o = sum;
        endcase
    end
endmodule

module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_serial_ctrl_if.slave   bus
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_XOR  = 3'b010,
        OP_SLT  = 3'b011,
        OP_AND  = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_OR   = 3'b111
    } op_e;

    state_e           state_q, state_d;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    // Partial result holds only the WIDTH-1 bits already produced
    logic [WIDTH-2:0] res_sh_q;

    logic [WIDTH-1:0] result_q;
    logic             carryout_q, overflow_q, zero_q;

    logic             slice_out, slice_cout;
    logic [WIDTH-1:0] res_full;
    logic             a_msb, b_msb, res_msb;
    logic             ovf_add, ovf_sub;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cout, fin_ovf, fin_zero;

    alu1bit u_slice (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .out_o  (slice_out),
        .cout_o (slice_cout)
    );

    assign last_bit = (state_q == S_RUN) && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                if (last_bit) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Final-bit evaluation: the slice is looking at the sign bits this cycle
    always_comb begin
        res_full = {slice_out, res_sh_q};
        a_msb    = a_sh_q[0];
        b_msb    = b_sh_q[0];
        res_msb  = slice_out;
        ovf_add  = (a_msb == b_msb) && (res_msb != a_msb);
        ovf_sub  = (a_msb != b_msb) && (res_msb != a_msb);
        fin_res  = res_full;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;
        case (op_e'(op_q))
            OP_ADD: begin
                fin_cout = slice_cout;
                fin_ovf  = ovf_add;
            end
            OP_SUB: begin
                fin_cout = slice_cout;
                fin_ovf  = ovf_sub;
            end
            OP_SLT: begin
                fin_res  = {{(WIDTH-1){1'b0}}, res_msb ^ ovf_sub};
                fin_cout = slice_cout;
            end
            default: ;
        endcase
        fin_zero = (fin_res == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            op_q       <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            res_sh_q   <= '0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh_q  <= bus.a;
                b_sh_q  <= bus.b;
                op_q    <= bus.op;
                carry_q <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
                idx_q   <= '0;
            end else if (state_q == S_RUN) begin
                a_sh_q   <= a_sh_q >> 1;
                b_sh_q   <= b_sh_q >> 1;
                carry_q  <= slice_cout;
                idx_q    <= idx_q + IW'(1);
                res_sh_q <= res_full[WIDTH-1:1];
            end
            if (last_bit) begin
                result_q   <= fin_res;
                carryout_q <= fin_cout;
                overflow_q <= fin_ovf;
                zero_q     <= fin_zero;
            end
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.carryout = carryout_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for the bit-serial ALU sequencer: latency, flags, handshake and reset.
module tb_alu_serial_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    int   lat, bcnt;
    logic [W-1:0] r1;
    logic saw_done;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();
    alu_serial_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one request, scrambles inputs afterwards,
    // optionally pulses start at cycle pulse_at, and returns at the done cycle.
    task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int pulse_at, output int lat_o, output int busy_o,
                      output logic [W-1:0] res1_o);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = ~op; bus.a = ~a; bus.b = a ^ b;
        lat_o = 1; busy_o = 0; res1_o = bus.result;
        while (!bus.done && lat_o < 100) begin
            if (bus.busy) busy_o++;
            @(negedge clk);
            lat_o++;
            bus.start = (lat_o == pulse_at);
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [W-1:0] res,
                            input logic c, input logic v, input logic z);
        chk({tag, ".lat"},  W'(lat), 33);
        chk({tag, ".res"},  bus.result, res);
        chk({tag, ".cout"}, W'(bus.carryout), W'(c));
        chk({tag, ".ovf"},  W'(bus.overflow), W'(v));
        chk({tag, ".zero"}, W'(bus.zero), W'(z));
        chk({tag, ".busy"}, W'(bus.busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst.busy", W'(bus.busy), 0);
        chk("rst.done", W'(bus.done), 0);
        chk("rst.res",  bus.result, 0);
        chk("rst.cout", W'(bus.carryout), 0);
        chk("rst.ovf",  W'(bus.overflow), 0);
        chk("rst.zero", W'(bus.zero), 0);
        reset = 1'b0;

        @(negedge clk);
        go(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, bcnt, r1);
        chk("add.busycnt", W'(bcnt), 32);
        chk_done("add", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("add.donepulse", W'(bus.done), 0);

        go(3'b001, 32'h8000_0000, 32'h0000_0001, 0, lat, bcnt, r1);
        chk_done("sub", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        go(3'b011, 32'hFFFF_FFFB, 32'h0000_0003, 0, lat, bcnt, r1);
        chk_done("slt1", 32'h0000_0001, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        go(3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 0, lat, bcnt, r1);
        chk_done("slt2", 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        go(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt, r1);
        chk_done("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        go(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt, r1);
        chk_done("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        go(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt, r1);
        chk_done("nand", 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        go(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt, r1);
        chk_done("nor", 32'h000F_000F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        go(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, bcnt, r1);
        chk_done("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);

        // start pulsed mid-run must be dropped, not queued
        @(negedge clk);
        go(3'b000, 32'h0000_0005, 32'h0000_0007, 5, lat, bcnt, r1);
        chk_done("ign", 32'h0000_000C, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ign.nobusy", W'(bus.busy), 0);
        chk("ign.nodone", W'(bus.done), 0);

        // back-to-back accept in the DONE cycle
        @(negedge clk);
        go(3'b001, 32'h0000_000A, 32'h0000_0003, 0, lat, bcnt, r1);
        chk_done("b2b1", 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        go(3'b010, 32'h1234_5678, 32'hFFFF_FFFF, 0, lat, bcnt, r1);
        chk("b2b2.hold", r1, 32'h0000_0007);
        chk("b2b2.busycnt", W'(bcnt), 32);
        chk_done("b2b2", 32'hEDCB_A987, 1'b0, 1'b0, 1'b0);

        // reset mid-op, held together with start
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'h0000_0011; bus.b = 32'h0000_0022;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        chk("rmid.busy", W'(bus.busy), 0);
        chk("rmid.done", W'(bus.done), 0);
        chk("rmid.res",  bus.result, 0);
        chk("rmid.cout", W'(bus.carryout), 0);
        chk("rmid.ovf",  W'(bus.overflow), 0);
        chk("rmid.zero", W'(bus.zero), 0);
        reset = 1'b0; bus.start = 1'b0;
        saw_done = 1'b0;
        repeat (29) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("rmid.quiet", W'(saw_done), 0);

        go(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 0, lat, bcnt, r1);
        chk_done("fresh", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
